// File: rtl/stream_mux_n.sv
// stream_mux_n: NCH-channel valid/ready stream multiplexer with manual, fixed-priority
// and round-robin arbitration feeding one registered output stage (1-cycle latency).
module stream_mux_n #(
  parameter int DW = 4,
  parameter int SW = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [(2**SW)*DW-1:0] in_data,
  input  logic [(2**SW)-1:0]    in_valid,
  output logic [(2**SW)-1:0]    in_ready,
  input  logic [1:0]            mode,
  input  logic [SW-1:0]         sel,
  output logic [DW-1:0]         out_data,
  output logic [SW-1:0]         out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int NCH = 2**SW;
  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_RR     = 2'b10;

  logic [DW-1:0] r_out_data;
  logic [SW-1:0] r_out_ch;
  logic          r_out_valid;
  logic [SW-1:0] r_rr_ptr;

  logic          w_load;
  logic          w_found;
  logic          w_xfer;
  logic [SW-1:0] w_grant;
  logic [SW-1:0] w_idx;
  logic [DW-1:0] w_sel_data;

  // The output register may accept a word when empty or when being drained this cycle.
  assign w_load     = !r_out_valid || out_ready;
  assign w_xfer     = w_load && w_found && !rst;
  assign w_sel_data = in_data[int'(w_grant)*DW +: DW];

  // Candidate channel selection for the current mode; mode 11 falls back to fixed priority.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    case (mode)
      MODE_MANUAL: begin
        w_grant = sel;
        w_found = in_valid[sel];
      end
      MODE_RR: begin
        // The SW-bit add wraps NCH-1 -> 0 for free.
        for (int i = 0; i < NCH; i++) begin
          w_idx = r_rr_ptr + SW'(i);
          if (!w_found && in_valid[w_idx]) begin
            w_grant = w_idx;
            w_found = 1'b1;
          end else begin
            w_grant = w_grant;
            w_found = w_found;
          end
        end
      end
      default: begin
        for (int i = NCH - 1; i >= 0; i--) begin
          if (in_valid[i]) begin
            w_grant = SW'(i);
            w_found = 1'b1;
          end else begin
            w_grant = w_grant;
            w_found = w_found;
          end
        end
      end
    endcase
  end

  // One-hot accept towards the granted channel, silent otherwise and during reset.
  always_comb begin
    in_ready = '0;
    if (w_xfer) begin
      in_ready = {{(NCH-1){1'b0}}, 1'b1} << w_grant;
    end else begin
      in_ready = '0;
    end
  end

  // Output register stage and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      if (w_found) begin
        r_out_data  <= w_sel_data;
        r_out_ch    <= w_grant;
        r_out_valid <= 1'b1;
        if (mode == MODE_RR) begin
          r_rr_ptr <= w_grant + SW'(1);
        end else begin
          r_rr_ptr <= r_rr_ptr;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end else begin
      r_out_data  <= r_out_data;
      r_out_ch    <= r_out_ch;
      r_out_valid <= r_out_valid;
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux_n.sv
// Self-checking bench for stream_mux_n: directed scenarios plus random traffic,
// compared against a queue-free behavioural model of the arbitration rules.
module tb_stream_mux_n;

  localparam int DW  = 4;
  localparam int SW  = 2;
  localparam int NCH = 4;

  logic              clk;
  logic              rst;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_ready;
  logic [1:0]        mode;
  logic [SW-1:0]     sel;
  logic [DW-1:0]     out_data;
  logic [SW-1:0]     out_ch;
  logic              out_valid;
  logic              out_ready;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_valid;
  int m_data;
  int m_ch;
  int m_ptr;
  int ch_data [NCH];

  stream_mux_n #(.DW(DW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int k = 0; k < NCH; k++) in_data[k*DW +: DW] = ch_data[k][DW-1:0];
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
  endtask

  // Which channel the rules pick this cycle; found=0 when nothing eligible.
  task automatic model_pick(output int found, output int g);
    found = 0; g = 0;
    if (mode == 2'b00) begin
      g = int'(sel);
      found = in_valid[g] ? 1 : 0;
    end else if (mode == 2'b10) begin
      for (int i = NCH - 1; i >= 0; i--)
        if (in_valid[(m_ptr + i) % NCH]) begin found = 1; g = (m_ptr + i) % NCH; end
    end else begin
      for (int k = NCH - 1; k >= 0; k--)
        if (in_valid[k]) begin found = 1; g = k; end
    end
  endtask

  // One clock: check in_ready before the edge, advance model, check outputs after.
  task automatic step();
    int found, g, load;
    logic [31:0] exp_rdy;
    pack();
    #1;
    model_pick(found, g);
    load = (m_valid == 0 || out_ready) ? 1 : 0;
    exp_rdy = (load != 0 && found != 0) ? (32'd1 << g) : 32'd0;
    chk("in_ready", {28'd0, in_ready}, exp_rdy);
    @(posedge clk);
    if (load != 0) begin
      if (found != 0) begin
        m_valid = 1; m_data = ch_data[g] % 16; m_ch = g;
        if (mode == 2'b10) m_ptr = (g + 1) % NCH;
      end else begin
        m_valid = 0;
      end
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, m_valid);
    chk("out_data",  {28'd0, out_data},  m_data);
    chk("out_ch",    {30'd0, out_ch},    m_ch);
  endtask

  initial begin
    int exp_ch [5];
    int exp_dt [5];
    exp_ch = '{0, 1, 2, 3, 0};
    exp_dt = '{1, 2, 3, 4, 1};

    // Reset with all channels requesting
    rst = 1'b1; in_valid = 4'b1111; mode = 2'b00; sel = 2'd0; out_ready = 1'b1;
    for (int k = 0; k < NCH; k++) ch_data[k] = 4'h7;
    pack();
    model_reset();
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {28'd0, out_data},  32'd0);
    chk("rst_out_ch",    {30'd0, out_ch},    32'd0);
    chk("rst_in_ready",  {28'd0, in_ready},  32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Manual mode: grant sel=2, then an idle sel drops out_valid
    mode = 2'b00; sel = 2'd2; in_valid = 4'b0100; ch_data[2] = 4'hA; out_ready = 1'b1;
    step();
    chk("man_data", {28'd0, out_data}, 32'hA);
    chk("man_ch",   {30'd0, out_ch},   32'd2);
    sel = 2'd1;
    step();
    chk("man_idle_valid", {31'd0, out_valid}, 32'd0);

    // Fixed priority: channel 1 wins every cycle over channel 3
    mode = 2'b01; in_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("fix_ch", {30'd0, out_ch}, 32'd1);
    end
    mode = 2'b11;
    step();
    chk("mode11_ch", {30'd0, out_ch}, 32'd1);

    // Round-robin sweep with wrap
    mode = 2'b10; in_valid = 4'b1111;
    for (int k = 0; k < NCH; k++) ch_data[k] = 1 + k;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("rr_ch",   {30'd0, out_ch},   exp_ch[c]);
      chk("rr_data", {28'd0, out_data}, exp_dt[c]);
    end

    // Backpressure: hold 5 for three cycles, then reload without a bubble
    mode = 2'b00; sel = 2'd0; in_valid = 4'b0001; ch_data[0] = 4'h5;
    step();
    out_ready = 1'b0; ch_data[0] = 4'h6;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_hold", {28'd0, out_data}, 32'h5);
    end
    out_ready = 1'b1;
    step();
    chk("bp_reload", {28'd0, out_data}, 32'h6);
    chk("bp_valid",  {31'd0, out_valid}, 32'd1);

    // Reset mid-operation in round-robin mode with rr_ptr at 2
    mode = 2'b10; in_valid = 4'b1111;
    step();
    chk("pre_rst_ch", {30'd0, out_ch}, 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data",  {28'd0, out_data},  32'd0);
    chk("mid_rst_ready", {28'd0, in_ready},  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    chk("post_rst_ch", {30'd0, out_ch}, 32'd0);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      mode      = 2'($urandom_range(0, 3));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NCH; k++) ch_data[k] = $urandom_range(0, 15);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
